// File: rtl/mem_wb_stage.sv
// MEM/WB stage register with valid/ready handshake and synchronous flush.
// SKID=1 gives a two-entry skid buffer with registered ready; SKID=0 a single register.
module mem_wb_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CTRL_W = 2,
   parameter int SKID   = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [CTRL_W-1:0] wb_i,
   input  logic [DATA_W-1:0] memdata_i,
   input  logic [DATA_W-1:0] aluresult_i,
   input  logic [ADDR_W-1:0] writeaddr_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [CTRL_W-1:0] wb_o,
   output logic [DATA_W-1:0] memdata_o,
   output logic [DATA_W-1:0] aluresult_o,
   output logic [ADDR_W-1:0] writeaddr_o
);

   localparam int E_W = CTRL_W + 2*DATA_W + ADDR_W;

   // Whole entry travels as one vector so fields can never mix between entries.
   logic [E_W-1:0] in_e;
   logic [E_W-1:0] out_e;
   logic           out_valid;
   logic           accept;
   logic           out_free;

   assign in_e     = {wb_i, memdata_i, aluresult_i, writeaddr_i};
   assign accept   = valid_i & ready_o;
   assign out_free = ~out_valid | ready_i;

   generate
      if (SKID != 0) begin : g_skid
         logic [E_W-1:0] skid_e;
         logic           skid_valid;

         // Ready comes straight from a flop: no path from ready_i.
         assign ready_o = ~skid_valid;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               out_valid  <= 1'b0;
               skid_valid <= 1'b0;
               out_e      <= '0;
               skid_e     <= '0;
            end else if (flush_i) begin
               out_valid  <= 1'b0;
               skid_valid <= 1'b0;
            end else if (out_free) begin
               if (skid_valid) begin
                  out_e      <= skid_e;
                  out_valid  <= 1'b1;
                  skid_valid <= 1'b0;
               end else if (accept) begin
                  out_e     <= in_e;
                  out_valid <= 1'b1;
               end else begin
                  out_valid <= 1'b0;
               end
            end else if (accept) begin
               skid_e     <= in_e;
               skid_valid <= 1'b1;
            end
         end
      end else begin : g_single
         assign ready_o = out_free;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               out_valid <= 1'b0;
               out_e     <= '0;
            end else if (flush_i) begin
               out_valid <= 1'b0;
            end else if (accept) begin
               out_e     <= in_e;
               out_valid <= 1'b1;
            end else if (out_valid & ready_i) begin
               out_valid <= 1'b0;
            end
         end
      end
   endgenerate

   assign valid_o     = out_valid;
   assign wb_o        = out_valid ? out_e[E_W-1 -: CTRL_W] : '0;
   assign memdata_o   = out_e[ADDR_W+2*DATA_W-1 -: DATA_W];
   assign aluresult_o = out_e[ADDR_W+DATA_W-1 -: DATA_W];
   assign writeaddr_o = out_e[ADDR_W-1:0];

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM/WB pipeline stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It sits between the memory-access stage and register write-back. It carries the write-back control bits, memory read data, ALU result and destination register address. Unlike a free-running stage register, it can stall, hold data under back-pressure and insert bubbles, and its widths are generic.

## Interface
- DATA_W, 32: width of memdata and aluresult.
- ADDR_W, 5: width of the destination register address.
- CTRL_W, 2: width of the write-back control field. Bit 0 is RegWrite; bit 1 is MemtoReg.
- SKID, 1: 1 selects a registered-ready two-entry skid buffer; 0 selects a single register with combinational ready.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  synchronous flush; discards all held entries.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  stage can accept an entry this cycle.
- wb_i  in  CTRL_W  write-back control.
- memdata_i  in  DATA_W  memory read data.
- aluresult_i  in  DATA_W  ALU result.
- writeaddr_i  in  ADDR_W  destination register.
- valid_o  out  1  output entry valid.
- ready_i  in  1  downstream accepts the output entry.
- wb_o  out  CTRL_W  write-back control. It is forced to 0 whenever valid_o=0.
- memdata_o  out  DATA_W  registered memory data.
- aluresult_o  out  DATA_W  registered ALU result.
- writeaddr_o  out  ADDR_W  registered destination register.

## Operation
- Definitions:
  - Accept = valid_i & ready_o.
  - Drain = valid_o & ready_i.
  - An entry is {wb, memdata, aluresult, writeaddr}, moved as one unit; fields are never mixed across entries.
- Reset (rst_i=1, asynchronous):
  - valid_o=0, skid_valid=0, all data registers 0, wb_o=0.
  - ready_o=1 with SKID=1. With SKID=0, ready_o follows its equation and evaluates to 1.
- Flush (flush_i=1 at a clock edge) has priority over every other action:
  - valid_o and skid_valid clear.
  - An entry presented in the same cycle is dropped, even if ready_o=1.
  - Data registers may keep stale values; wb_o still reads 0 because valid_o=0.
- SKID=0:
  - ready_o = ~valid_o | ready_i, combinational.
  - On Accept, the output register loads the input and valid_o becomes 1.
  - Else on Drain, valid_o becomes 0.
  - Else the output holds.
- SKID=1 (states EMPTY, ONE = output register valid, TWO = output and skid both valid):
  - ready_o = ~skid_valid, registered, with no combinational path from ready_i.
  - Output register free (~valid_o | ready_i):
    - If skid_valid: the output loads from skid and skid_valid clears (TWO→ONE).
    - Else if Accept: the output loads from the input (EMPTY→ONE, or ONE→ONE under simultaneous Drain).
    - Else valid_o becomes 0 (ONE→EMPTY).
  - Output register blocked (valid_o & ~ready_i):
    - If Accept: skid loads from the input and skid_valid becomes 1 (ONE→TWO).
    - In TWO, Accept cannot occur because ready_o=0.
  - Ordering is strictly FIFO. No entry is lost or duplicated without a flush.

## Timing
- Latency: an entry accepted at edge N appears on the outputs after edge N, when the output register was free.
- Throughput: one entry per cycle while ready_i=1, in both modes.
- SKID=1 back-pressure:
  - ready_o deasserts the cycle after the skid fills.
  - When ready_i first drops, at most one extra entry is absorbed.
- Outputs change only on clk_i edges or on rst_i assertion.
- Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.

## Test plan
- Streaming:
  - Stimulus: SKID=1, ready_i=1, five entries with aluresult 1..5 and wb=2'b01 on consecutive cycles.
  - Response: valid_o high for 5 cycles, each one edge after input; aluresult_o reads 1..5 in order.
- Back-pressure:
  - Stimulus: entries A, B, C; ready_i=0 from the cycle A appears on the output.
  - Response: B goes to the skid, ready_o=0, C is held upstream.
  - Stimulus: raise ready_i.
  - Response: A, B, C drain in order, one per cycle.
- Flush with a full skid:
  - Stimulus: state TWO, flush_i=1 together with valid_i=1.
  - Response: next cycle valid_o=0, wb_o=0, ready_o=1, and the incoming entry never appears.
- Asynchronous reset:
  - Stimulus: pulse rst_i between edges while in state TWO.
  - Response: valid_o=0, wb_o=0, memdata_o=0 immediately; ready_o=1.
- SKID=0 stall:
  - Stimulus: valid_o=1, ready_i=0.
  - Response: ready_o=0 combinationally and the output holds.
  - Stimulus: ready_i=1 together with valid_i=1.
  - Response: the new entry replaces the old in one edge.
- Parameters:
  - Stimulus: DATA_W=64, ADDR_W=6, CTRL_W=3, memdata_i=64'hDEAD_BEEF_0123_4567, writeaddr_i=6'd63.
  - Response: both values come out unchanged on the outputs.
